// File: rtl/captured_sample_reader_if.sv
// Read-port bundle for captured_sample_reader.
// The slave modport is the buffer side. The master modport is the capture/consumer side.
interface captured_sample_reader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             data_out_ready;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             overflow_clr;

    modport master (
        output data_in, data_in_valid, data_out_ready, overflow_clr,
        input  data_out, data_out_valid, level, overflow
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready, overflow_clr,
        output data_out, data_out_valid, level, overflow
    );
endinterface

// File: rtl/captured_sample_reader.sv
// captured_sample_reader: small circular capture buffer with a registered valid/ready read port.
// The module reports its fill level and sets a sticky overflow flag when a capture is dropped.
// Optional build macro CAPTURED_SAMPLE_READER_DROP_OLDEST_EN changes what happens when a
// capture arrives while the buffer is full. With the macro defined, the new sample overwrites
// the oldest entry. With the macro undefined, the new sample is dropped.
module captured_sample_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    captured_sample_reader_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_wr;
    logic             w_rd_adv;
    logic [PTR_W-1:0] w_rp_nxt;

    assign w_full   = (r_level == LVL_W'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_pop    = !w_empty && bus.data_out_ready;
    assign w_push   = bus.data_in_valid && (!w_full || w_pop);
    assign w_drop   = bus.data_in_valid && w_full && !w_pop;
    assign w_rp_nxt = r_rp + 1'b1;

`ifdef CAPTURED_SAMPLE_READER_DROP_OLDEST_EN
    // A drop overwrites the oldest slot. When full, wp equals rp, so both pointers advance together.
    assign w_wr     = w_push || w_drop;
    assign w_rd_adv = w_pop || w_drop;
`else
    assign w_wr     = w_push;
    assign w_rd_adv = w_pop;
`endif

    // Sample storage, deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= bus.data_in;
        end
    end

    // Pointers, fill counter, registered head-of-queue and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_dout  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_adv) begin
                r_rp <= w_rp_nxt;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
            // The next head may be the slot being written this cycle, so bypass data_in into it.
            if (w_rd_adv) begin
                r_dout <= (w_wr && (r_wp == w_rp_nxt)) ? bus.data_in : r_mem[w_rp_nxt];
            end else if (w_wr && w_empty) begin
                r_dout <= bus.data_in;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.overflow_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.data_out       = r_dout;
    assign bus.data_out_valid = !w_empty;
    assign bus.level          = r_level;
    assign bus.overflow       = r_ovf;
endmodule

// File: tb/tb_captured_sample_reader.sv
// Testbench for captured_sample_reader. A queue-based reference model predicts every output.
module tb_captured_sample_reader;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    captured_sample_reader_if #(.WIDTH(W), .DEPTH(D)) bus ();
    captured_sample_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned tests  = 0;
    int unsigned failed = 0;

    logic [W-1:0] q[$];
    bit           m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("valid", 32'(bus.data_out_valid), 32'(q.size() != 0));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (q.size() != 0) chk("data_out", 32'(bus.data_out), 32'(q[0]));
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit c);
        bus.data_in_valid  = v;
        bus.data_in        = d;
        bus.data_out_ready = r;
        bus.overflow_clr   = c;
    endtask

    // Reference model: apply one clock of queue semantics, then compare after the edge.
    task automatic tick();
        bit pop;
        bit full;
        pop  = (q.size() != 0) && bus.data_out_ready;
        full = (q.size() == D);
        if (pop) void'(q.pop_front());
        if (bus.data_in_valid) begin
            if (!full || pop) begin
                q.push_back(bus.data_in);
            end else begin
`ifdef CAPTURED_SAMPLE_READER_DROP_OLDEST_EN
                void'(q.pop_front());
                q.push_back(bus.data_in);
`endif
            end
        end
        if (bus.data_in_valid && full && !pop) m_ovf = 1'b1;
        else if (bus.overflow_clr)             m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        drive(0, '0, 0, 0);
        #12;
        check_all();
        chk("reset_dout", 32'(bus.data_out), 32'h0);
        rst = 1'b0;

        // Idle after reset.
        repeat (5) tick();

        // In-order drain.
        drive(1, 8'h11, 0, 0); tick();
        drive(1, 8'h22, 0, 0); tick();
        drive(1, 8'h33, 0, 0); tick();
        drive(0, '0, 0, 0);
        chk("drain_level", 32'(bus.level), 32'd3);
        chk("drain_head", 32'(bus.data_out), 32'h11);
        drive(0, '0, 1, 0);
        repeat (4) tick();

        // Overflow on the fifth push into a DEPTH=4 buffer.
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'hA0 + i), 0, 0);
            tick();
        end
        drive(0, '0, 0, 0);
        chk("ovf_level", 32'(bus.level), 32'd4);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
`ifdef CAPTURED_SAMPLE_READER_DROP_OLDEST_EN
        chk("ovf_head", 32'(bus.data_out), 32'hA1);
`else
        chk("ovf_head", 32'(bus.data_out), 32'hA0);
`endif
        drive(0, '0, 1, 0);
        repeat (5) tick();
        drive(0, '0, 0, 1); tick();
        drive(0, '0, 0, 0);

        // Full with simultaneous push and pop is a normal write.
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'(8'hC0 + i), 0, 0);
            tick();
        end
        drive(1, 8'h55, 1, 0); tick();
        chk("full_pp_ovf", 32'(bus.overflow), 32'd0);
        chk("full_pp_level", 32'(bus.level), 32'd4);
        drive(0, '0, 1, 0);
        repeat (5) tick();

        // Backpressure: the head holds while two more samples arrive.
        drive(1, 8'h90, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive((i == 2) || (i == 5), 8'(8'h91 + i), 0, 0);
            tick();
        end
        chk("bp_level", 32'(bus.level), 32'd3);
        chk("bp_head", 32'(bus.data_out), 32'h90);

        // Clear and drop in the same cycle: set wins.
        drive(1, 8'h5A, 0, 0); tick();
        drive(1, 8'h5B, 0, 1); tick();
        chk("clr_vs_set", 32'(bus.overflow), 32'd1);
        drive(0, '0, 1, 1);
        repeat (5) tick();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            drive(bit'($urandom_range(0, 2) != 0), 8'($urandom), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 7) == 0));
            tick();
        end

        // Reset in the middle of a drain.
        drive(0, '0, 1, 0);
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'hE0 + i), 0, 0);
            tick();
        end
        drive(0, '0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_all();
        chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        #2;
        rst = 1'b0;
        drive(1, 8'h7E, 0, 0); tick();
        drive(0, '0, 0, 0);
        chk("post_rst_dout", 32'(bus.data_out), 32'h7E);
        chk("post_rst_valid", 32'(bus.data_out_valid), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
